ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//   Instruction fetch stage directly upstream of the decode stage.
//   - Owns the PC, issues one instruction-memory read at a time, captures the 32-bit word.
//   - Presents {inst, pc} to decode over a valid/ready handshake.
//   - Accepts PC redirects from execute (branch/jump) and discards stale responses.
// PARAMETERS
//   RESET_PC   32'h8000_0000   PC loaded on reset
//   ADDR_W     32              PC / memory address width
// PORTS
//   clk             in   1       single clock; all state updates on rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   imem_req_valid  out  1       read request valid
//   imem_req_ready  in   1       memory accepts request this cycle
//   imem_addr       out  ADDR_W  word-aligned read address ({pc[ADDR_W-1:2],2'b00})
//   imem_rsp_valid  in   1       read data valid; always accepted, no back-pressure
//   imem_rsp_data   in   32      instruction word
//   inst_valid      out  1       {inst,pc} valid to decode
//   inst_ready      in   1       decode consumes this cycle
//   inst            out  32      fetched instruction
//   pc              out  ADDR_W  address of inst
//   redirect_valid  in   1       load redirect_pc as next fetch PC
//   redirect_pc     in   ADDR_W  redirect target
// BEHAVIOUR
//   - Reset (async assert, sync deassert handled upstream): state=IDLE, pc_r=RESET_PC, drop=0.
//     imem_req_valid=0, inst_valid=0, inst=32'h0000_0013 (nop), pc=RESET_PC.
//   - FSM:
//     IDLE -> REQ unconditionally. First request issues on the 2nd cycle after rst_n rises.
//     REQ:  imem_req_valid=1. On imem_req_ready -> WAIT.
//     WAIT: on imem_rsp_valid with drop=0: latch inst, -> HOLD.
//           On imem_rsp_valid with drop=1: discard data, clear drop, -> REQ.
//     HOLD: inst_valid=1. On inst_ready: pc_r <= pc_r+4, -> REQ.
//   - Throughput: one instruction per 3 cycles with 1-cycle memory and inst_ready=1.
//   - Single outstanding request; responses arrive >=1 cycle after acceptance, in order.
//   - Redirect (always wins over sequential pc+4; latest redirect wins):
//     REQ without req_ready: pc_r<=redirect_pc, stay REQ. The new address is presented next cycle.
//     REQ with req_ready same cycle: old-PC request is in flight. pc_r<=redirect_pc, drop<=1, -> WAIT.
//     WAIT: pc_r<=redirect_pc, drop<=1. Same-cycle rsp_valid is dropped as well.
//     HOLD: pc_r<=redirect_pc, inst_valid deasserts next cycle, -> REQ.
//       A same-cycle inst_ready transfer still counts; decode/execute flush it.
//     IDLE: pc_r<=redirect_pc.
//   - Outputs inst/pc are stable while inst_valid=1 && inst_ready=0.
//   - PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 wraps to 0.
//   - rst_n assertion mid-transaction abandons any in-flight request. Memory is reset by the same rst_n.
// CONFIGURATION
//   IFU_MISALIGN_CHK_EN defined:
//     - Extra output fetch_misalign (1b), valid with inst_valid, reset 0.
//     - If pc_r[1:0]!=0 on entering REQ: no memory request is issued.
//     - Go directly to HOLD with inst=32'h0000_0013 and fetch_misalign=1.
//     - Leave only via redirect; inst_ready does not advance the PC.
//   IFU_MISALIGN_CHK_EN undefined: no such port; pc[1:0] ignored for the memory address, pc output unmasked.
// STRUCTURE
//   Shared package ifu_pkg:
//     - state typedef {IDLE,REQ,WAIT,HOLD}
//     - RESET_PC_DEFAULT, INST_NOP=32'h0000_0013, INST_BYTES=4
//   Sub-module ifu_pc_gen: next-PC mux (redirect / pc+4 / hold) plus the PC register.
//   FSM and data latch stay in ifu_fetch.
// TESTING
//   1 Reset release, mem 1-cycle latency, data 32'h0000_0297, inst_ready=1
//     -> req addr 8000_0000 at cycle 2; inst_valid cycle 4 with pc=8000_0000; next req 8000_0004.
//   2 inst_ready=0 for 5 cycles in HOLD -> inst/pc stable, no new imem request.
//     Release -> next request to pc+4.
//   3 Redirect to 8000_0100 while WAIT -> response for old PC dropped (never on inst_valid).
//     Next request 8000_0100.
//   4 Redirect coincident with req accept, rsp 3 cycles later -> response dropped.
//     Next inst_valid carries pc=8000_0100.
//   5 Redirect to FFFF_FFFC, then sequential fetch -> next request address 0000_0000.
//   6 (IFU_MISALIGN_CHK_EN) Redirect to 8000_0002 -> no imem_req_valid.
//     inst_valid=1, fetch_misalign=1, inst=0000_0013; PC held until next redirect.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC register with its next-PC select: redirect, sequential advance, or hold.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Redirect beats the sequential step; the add wraps modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
        end
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: single outstanding imem read, valid/ready to decode,
// redirect with stale-response drop. Optional misalignment trap is enabled by
// defining IFU_MISALIGN_CHK_EN (adds the fetch_misalign output).
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic              fetch_misalign
`endif
);

    ifu_state_e        state_q;
    logic              drop_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_misal;
    logic              advance;

`ifdef IFU_MISALIGN_CHK_EN
    logic misal_q;
    assign pc_misal       = |pc_q[1:0];
    assign fetch_misalign = misal_q;
`else
    assign pc_misal = 1'b0;
`endif

    // A misaligned PC parks in HOLD; only a redirect moves it on.
    assign advance = (state_q == HOLD) && inst_ready && !pc_misal;

    ifu_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (advance),
        .pc_o             (pc_q)
    );

    assign imem_req_valid = (state_q == REQ) && !pc_misal;
    assign imem_addr      = {pc_q[ADDR_W-1:2], 2'b00};
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign pc             = pc_q;

    // Fetch sequencing, stale-response tracking and instruction latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            inst_q  <= INST_NOP;
`ifdef IFU_MISALIGN_CHK_EN
            misal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        // A redirect here leaves the old-PC read in flight; discard it.
                        state_q <= WAIT;
                        if (redirect_valid) drop_q <= 1'b1;
                    end else if (pc_misal && !redirect_valid) begin
                        state_q <= HOLD;
                        inst_q  <= INST_NOP;
`ifdef IFU_MISALIGN_CHK_EN
                        misal_q <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // A same-cycle redirect discards this response directly,
                        // so drop is not armed for a response that never comes.
                        if (drop_q || redirect_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            inst_q  <= imem_rsp_data;
                            state_q <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || advance) begin
                        state_q <= REQ;
`ifdef IFU_MISALIGN_CHK_EN
                        misal_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch with a latency-programmable memory model.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc;

    logic [31:0] exp_req[$];
    logic [31:0] obs_req[$];
    logic [63:0] exp_x[$];
    logic [63:0] obs_x[$];
    int          obs_xc[$];

    int          mem_lat;
    int          pend_cnt;
    logic        pend;
    logic [31:0] pend_data;

    ifu_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return a ^ 32'h8000_0297;
    endfunction

    // One clock: record handshakes seen before the edge, then advance the memory model.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        xf;
        logic [63:0] xv;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        xf  = inst_valid && inst_ready;
        xv  = {inst, pc};
        @(posedge clk);
        #1;
        cyc++;
        if (acc) obs_req.push_back(a);
        if (xf) begin
            obs_x.push_back(xv);
            obs_xc.push_back(cyc);
        end
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_data = memdata(a);
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_data;
                pend           = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pend           = 1'b0;
        pend_cnt       = 0;
        mem_lat        = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        exp_req.delete();
        obs_req.delete();
        exp_x.delete();
        obs_x.delete();
        obs_xc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        imem_req_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valids: req_valid=%b inst_valid=%b, want 0 0", imem_req_valid, inst_valid);
        end
        n_cmp++;
        if (inst !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL reset_inst: got %h want 00000013", inst);
        end
        n_cmp++;
        if (pc !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL reset_pc: got %h want 80000000", pc);
        end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        logic [31:0] o;
        logic [63:0] ex;
        logic [63:0] ox;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_req.push_back(32'h8000_0000);
        exp_req.push_back(32'h8000_0004);
        exp_req.push_back(32'h8000_0008);
        exp_x.push_back({memdata(32'h8000_0000), 32'h8000_0000});
        exp_x.push_back({memdata(32'h8000_0004), 32'h8000_0004});
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle_req: got %b want 0", imem_req_valid);
        end
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL basic_first_req: valid=%b addr=%h want 1 80000000", imem_req_valid, imem_addr);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_wait: inst_valid=%b want 0", inst_valid);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b1 || pc !== 32'h8000_0000 || inst !== 32'h0000_0297) begin
            n_err++;
            $display("FAIL basic_first_inst: v=%b pc=%h inst=%h want 1 80000000 00000297", inst_valid, pc, inst);
        end
        repeat (5) tick();
        n_cmp++;
        if (obs_xc.size() < 2 || obs_xc[1] - obs_xc[0] != 3) begin
            n_err++;
            $display("FAIL basic_throughput: %0d transfers, want 2 spaced by 3 cycles", obs_xc.size());
        end
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            n_cmp++;
            if (obs_req.size() == 0) begin
                n_err++;
                $display("FAIL basic_req: got none want %h", e);
            end else begin
                o = obs_req.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL basic_req: got %h want %h", o, e);
                end
            end
        end
        while (exp_x.size() > 0) begin
            ex = exp_x.pop_front();
            n_cmp++;
            if (obs_x.size() == 0) begin
                n_err++;
                $display("FAIL basic_xfer: got none want %h", ex);
            end else begin
                ox = obs_x.pop_front();
                if (ox !== ex) begin
                    n_err++;
                    $display("FAIL basic_xfer: got %h want %h", ox, ex);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] ex;
        logic [63:0] ox;
        do_reset();
        imem_req_ready = 1'b1;
        exp_x.push_back({memdata(32'h8000_0000), 32'h8000_0000});
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || pc !== 32'h8000_0000 ||
                inst !== memdata(32'h8000_0000)) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: v=%b req=%b pc=%h inst=%h", i, inst_valid, imem_req_valid, pc, inst);
            end
        end
        n_cmp++;
        if (obs_req.size() != 1) begin
            n_err++;
            $display("FAIL stall_reqcount: got %0d requests want 1", obs_req.size());
        end
        inst_ready = 1'b1;
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0004) begin
            n_err++;
            $display("FAIL stall_next_req: valid=%b addr=%h want 1 80000004", imem_req_valid, imem_addr);
        end
        while (exp_x.size() > 0) begin
            ex = exp_x.pop_front();
            n_cmp++;
            if (obs_x.size() == 0) begin
                n_err++;
                $display("FAIL stall_xfer: got none want %h", ex);
            end else begin
                ox = obs_x.pop_front();
                if (ox !== ex) begin
                    n_err++;
                    $display("FAIL stall_xfer: got %h want %h", ox, ex);
                end
            end
        end
    endtask

    // Redirect either during WAIT or on the accepting cycle; the old response must vanish.
    task automatic test_redirect(input bit on_accept);
        logic [31:0] e;
        logic [31:0] o;
        logic [63:0] ex;
        logic [63:0] ox;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 3;
        exp_req.push_back(32'h8000_0000);
        exp_req.push_back(32'h8000_0100);
        exp_x.push_back({memdata(32'h8000_0100), 32'h8000_0100});
        tick();
        if (!on_accept) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        if (on_accept) tick();
        mem_lat = 1;
        repeat (2) tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL redir%0d_req: valid=%b addr=%h want 1 80000100", on_accept, imem_req_valid, imem_addr);
        end
        repeat (2) tick();
        n_cmp++;
        if (inst_valid !== 1'b1 || pc !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL redir%0d_inst: v=%b pc=%h want 1 80000100", on_accept, inst_valid, pc);
        end
        tick();
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            n_cmp++;
            if (obs_req.size() == 0) begin
                n_err++;
                $display("FAIL redir%0d_reqseq: got none want %h", on_accept, e);
            end else begin
                o = obs_req.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL redir%0d_reqseq: got %h want %h", on_accept, o, e);
                end
            end
        end
        while (exp_x.size() > 0) begin
            ex = exp_x.pop_front();
            n_cmp++;
            if (obs_x.size() == 0) begin
                n_err++;
                $display("FAIL redir%0d_xfer: got none want %h", on_accept, ex);
            end else begin
                ox = obs_x.pop_front();
                if (ox !== ex) begin
                    n_err++;
                    $display("FAIL redir%0d_xfer: got %h want %h", on_accept, ox, ex);
                end
            end
        end
        n_cmp++;
        if (obs_x.size() != 0) begin
            n_err++;
            $display("FAIL redir%0d_extra: %0d unexpected transfers, want 0", on_accept, obs_x.size());
        end
    endtask

    task automatic test_redirect_hold();
        logic [63:0] ex;
        logic [63:0] ox;
        do_reset();
        imem_req_ready = 1'b1;
        exp_x.push_back({memdata(32'h8000_0200), 32'h8000_0200});
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0200) begin
            n_err++;
            $display("FAIL hold_redir: v=%b req=%b addr=%h want 0 1 80000200", inst_valid, imem_req_valid, imem_addr);
        end
        inst_ready = 1'b1;
        repeat (3) tick();
        while (exp_x.size() > 0) begin
            ex = exp_x.pop_front();
            n_cmp++;
            if (obs_x.size() == 0) begin
                n_err++;
                $display("FAIL hold_xfer: got none want %h", ex);
            end else begin
                ox = obs_x.pop_front();
                if (ox !== ex) begin
                    n_err++;
                    $display("FAIL hold_xfer: got %h want %h", ox, ex);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        logic [31:0] o;
        do_reset();
        inst_ready = 1'b1;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_first: valid=%b addr=%h want 1 fffffffc", imem_req_valid, imem_addr);
        end
        repeat (3) tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0000 || pc !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_next: valid=%b addr=%h pc=%h want 1 00000000 00000000", imem_req_valid, imem_addr, pc);
        end
        tick();
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            n_cmp++;
            if (obs_req.size() == 0) begin
                n_err++;
                $display("FAIL wrap_req: got none want %h", e);
            end else begin
                o = obs_req.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL wrap_req: got %h want %h", o, e);
                end
            end
        end
    endtask

`ifdef IFU_MISALIGN_CHK_EN
    task automatic test_misalign();
        logic [31:0] e;
        logic [31:0] o;
        logic [63:0] ex;
        logic [63:0] ox;
        do_reset();
        inst_ready = 1'b1;
        exp_req.push_back(32'h8000_0300);
        for (int i = 0; i < 5; i++) exp_x.push_back({32'h0000_0013, 32'h8000_0002});
        exp_x.push_back({memdata(32'h8000_0300), 32'h8000_0300});
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mis_noreq: got %b want 0", imem_req_valid);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b1 || fetch_misalign !== 1'b1 || inst !== 32'h0000_0013 || pc !== 32'h8000_0002) begin
            n_err++;
            $display("FAIL mis_hold: v=%b mis=%b inst=%h pc=%h", inst_valid, fetch_misalign, inst, pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || pc !== 32'h8000_0002) begin
                n_err++;
                $display("FAIL mis_stuck[%0d]: v=%b req=%b pc=%h", i, inst_valid, imem_req_valid, pc);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (fetch_misalign !== 1'b0 || inst !== memdata(32'h8000_0300)) begin
            n_err++;
            $display("FAIL mis_recover: mis=%b inst=%h", fetch_misalign, inst);
        end
        tick();
        while (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            n_cmp++;
            if (obs_req.size() == 0) begin
                n_err++;
                $display("FAIL mis_req: got none want %h", e);
            end else begin
                o = obs_req.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL mis_req: got %h want %h", o, e);
                end
            end
        end
        while (exp_x.size() > 0) begin
            ex = exp_x.pop_front();
            n_cmp++;
            if (obs_x.size() == 0) begin
                n_err++;
                $display("FAIL mis_xfer: got none want %h", ex);
            end else begin
                ox = obs_x.pop_front();
                if (ox !== ex) begin
                    n_err++;
                    $display("FAIL mis_xfer: got %h want %h", ox, ex);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_redirect_hold();
        test_wrap();
`ifdef IFU_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
